// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, default sizes and one-hot helper for timer_arbiter
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ = 2;
  function automatic logic [31:0] onehot(input int idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: requester-facing bus of the shared timer
interface timer_arbiter_if #(
  parameter int WIDTH = timer_pkg::DEF_WIDTH,
  parameter int NREQ = timer_pkg::DEF_NREQ
);
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic busy;
  logic [WIDTH-1:0] count;
  modport master (output req, len, input grant, done, busy, count);
  modport slave (input req, len, output grant, done, busy, count);
endinterface

// File: rtl/timer_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector starting after the last winner
module rr_pick #(
  parameter int NREQ = timer_pkg::DEF_NREQ,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0] last,
  output logic valid,
  output logic [IW-1:0] winner
);
  logic [IW-1:0] idx;
  // Scan farthest-first so the nearest asserted requester after last wins.
  always_comb begin
    valid = |req;
    winner = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NREQ);
      winner = req[idx] ? idx : winner;
    end
  end
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sequencer sharing one up-counter among requesters
module timer_arbiter
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ = DEF_NREQ,
  localparam int IW = $clog2(NREQ)
) (
  input logic clk,
  input logic reset,
  timer_arbiter_if.slave bus
);
  state_t state;
  logic [WIDTH-1:0] target;
  logic [IW-1:0] owner, last, pick_w;
  logic pick_v;
  rr_pick #(.NREQ(NREQ)) u_pick (.req(bus.req), .last(last), .valid(pick_v), .winner(pick_w));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.done <= '0;
      bus.busy <= 1'b0;
      bus.count <= '0;
      target <= '0;
      owner <= '0;
      last <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          bus.done <= '0;
          bus.count <= '0;
          if (pick_v) begin
            state <= RUN;
            bus.grant <= NREQ'(onehot(int'(pick_w)));
            bus.busy <= 1'b1;
            target <= bus.len[int'(pick_w)*WIDTH +: WIDTH];
            owner <= pick_w;
            last <= pick_w;
          end
        end
        RUN: begin
          if (!bus.req[owner]) begin
            state <= IDLE;
            bus.grant <= '0;
            bus.busy <= 1'b0;
            bus.count <= '0;
          end else if (bus.count == target) begin
            state <= DONE;
            bus.done <= NREQ'(onehot(int'(owner)));
          end else begin
            bus.count <= bus.count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          bus.done <= '0;
          bus.grant <= '0;
          bus.busy <= 1'b0;
          bus.count <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed self-checking bench for timer_arbiter
module tb_timer_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  timer_arbiter_if #(.WIDTH(4), .NREQ(2)) bus();
  timer_arbiter #(.WIDTH(4), .NREQ(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic expo(input string tag, input logic [1:0] g, input logic [1:0] d, input logic b, input logic [3:0] c);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".done"}, 32'(bus.done), 32'(d));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
  endtask
  initial begin
    bus.req = 2'b11;
    bus.len = {4'd1, 4'd3};
    for (int i = 0; i < 3; i++) begin
      step();
      expo("reset_hold", 2'b00, 2'b00, 1'b0, 4'd0);
    end
    reset = 1'b0;
    step();
    expo("post_reset_grant", 2'b01, 2'b00, 1'b1, 4'd0);
    bus.req = 2'b00;
    step();
    expo("post_reset_abort", 2'b00, 2'b00, 1'b0, 4'd0);
    bus.req = 2'b01;
    bus.len = {4'd1, 4'd3};
    step();
    expo("solo_c1", 2'b01, 2'b00, 1'b1, 4'd0);
    bus.len = {4'd1, 4'd1};
    for (int i = 1; i <= 3; i++) begin
      step();
      expo("solo_run", 2'b01, 2'b00, 1'b1, 4'(i));
    end
    step();
    expo("solo_done", 2'b01, 2'b01, 1'b1, 4'd3);
    bus.req = 2'b00;
    step();
    expo("solo_idle", 2'b00, 2'b00, 1'b0, 4'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req = 2'b11;
    bus.len = {4'd1, 4'd2};
    step();
    expo("rr_c1", 2'b01, 2'b00, 1'b1, 4'd0);
    step();
    expo("rr_c2", 2'b01, 2'b00, 1'b1, 4'd1);
    step();
    expo("rr_c3", 2'b01, 2'b00, 1'b1, 4'd2);
    step();
    expo("rr_done0", 2'b01, 2'b01, 1'b1, 4'd2);
    step();
    expo("rr_c5", 2'b00, 2'b00, 1'b0, 4'd0);
    step();
    expo("rr_c6", 2'b10, 2'b00, 1'b1, 4'd0);
    step();
    expo("rr_c7", 2'b10, 2'b00, 1'b1, 4'd1);
    step();
    expo("rr_done1", 2'b10, 2'b10, 1'b1, 4'd1);
    step();
    expo("rr_c9", 2'b00, 2'b00, 1'b0, 4'd0);
    step();
    expo("rr_again0", 2'b01, 2'b00, 1'b1, 4'd0);
    bus.req = 2'b00;
    step();
    expo("rr_abort", 2'b00, 2'b00, 1'b0, 4'd0);
    bus.req = 2'b01;
    bus.len = {4'd1, 4'd0};
    step();
    expo("len0_run", 2'b01, 2'b00, 1'b1, 4'd0);
    step();
    expo("len0_done", 2'b01, 2'b01, 1'b1, 4'd0);
    bus.req = 2'b00;
    step();
    expo("len0_idle", 2'b00, 2'b00, 1'b0, 4'd0);
    bus.req = 2'b01;
    bus.len = {4'd1, 4'd15};
    for (int i = 0; i <= 15; i++) begin
      step();
      expo("len15_run", 2'b01, 2'b00, 1'b1, 4'(i));
    end
    step();
    expo("len15_done", 2'b01, 2'b01, 1'b1, 4'd15);
    bus.req = 2'b00;
    step();
    expo("len15_idle", 2'b00, 2'b00, 1'b0, 4'd0);
    bus.req = 2'b01;
    bus.len = {4'd1, 4'd10};
    step();
    expo("abort_c1", 2'b01, 2'b00, 1'b1, 4'd0);
    bus.req = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      step();
      expo("abort_run", 2'b01, 2'b00, 1'b1, 4'(i));
    end
    bus.req = 2'b10;
    step();
    expo("abort_idle", 2'b00, 2'b00, 1'b0, 4'd0);
    step();
    expo("abort_pending1", 2'b10, 2'b00, 1'b1, 4'd0);
    bus.req = 2'b00;
    step();
    expo("abort_pending1_drop", 2'b00, 2'b00, 1'b0, 4'd0);
    bus.req = 2'b01;
    bus.len = {4'd1, 4'd15};
    for (int i = 0; i <= 5; i++) begin
      step();
      expo("midrst_run", 2'b01, 2'b00, 1'b1, 4'(i));
    end
    reset = 1'b1;
    bus.req = 2'b11;
    step();
    expo("midrst_reset", 2'b00, 2'b00, 1'b0, 4'd0);
    reset = 1'b0;
    step();
    expo("midrst_regrant0", 2'b01, 2'b00, 1'b1, 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
